// File: rtl/factorial_ctrl.sv
// Moore controller sequencing a register-file/ALU datapath to compute n! mod 256.
// R0 holds the down-counter, R1 the accumulator, R2 the constant one.
module factorial_ctrl #(
    parameter logic [2:0] SEL_PASS_A = 3'b000,
    parameter logic [2:0] SEL_SUB    = 3'b001,
    parameter logic [2:0] SEL_MUL    = 3'b010
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] n_i,
    input  logic       compare,
    output logic       busy,
    output logic       done,
    output logic [7:0] data_o,
    output logic       IE,
    output logic       we,
    output logic [1:0] wa,
    output logic       rea,
    output logic [1:0] raa,
    output logic       reb,
    output logic [1:0] rab,
    output logic       OE,
    output logic [2:0] Sel_alu
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        LOAD_N   = 4'd1,
        LOAD_ACC = 4'd2,
        LOAD_ONE = 4'd3,
        CHECK    = 4'd4,
        MUL      = 4'd5,
        DEC      = 4'd6,
        OUT      = 4'd7,
        DONE     = 4'd8
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] n_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            n_q     <= 8'd0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start)
                n_q <= n_i;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b1;
        done    = 1'b0;
        data_o  = 8'd0;
        IE      = 1'b0;
        we      = 1'b0;
        wa      = 2'd0;
        rea     = 1'b0;
        raa     = 2'd0;
        reb     = 1'b0;
        rab     = 2'd0;
        OE      = 1'b0;
        Sel_alu = SEL_PASS_A;
        unique case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start)
                    state_d = LOAD_N;
            end
            LOAD_N: begin
                // 0! is folded into 1! so the loop always terminates
                IE      = 1'b1;
                we      = 1'b1;
                wa      = 2'd0;
                data_o  = (n_q == 8'd0) ? 8'd1 : n_q;
                state_d = LOAD_ACC;
            end
            LOAD_ACC: begin
                IE      = 1'b1;
                we      = 1'b1;
                wa      = 2'd1;
                data_o  = 8'd1;
                state_d = LOAD_ONE;
            end
            LOAD_ONE: begin
                IE      = 1'b1;
                we      = 1'b1;
                wa      = 2'd2;
                data_o  = 8'd1;
                state_d = CHECK;
            end
            CHECK: begin
                rea     = 1'b1;
                raa     = 2'd0;
                Sel_alu = SEL_PASS_A;
                state_d = compare ? OUT : MUL;
            end
            MUL: begin
                rea     = 1'b1;
                raa     = 2'd1;
                reb     = 1'b1;
                rab     = 2'd0;
                Sel_alu = SEL_MUL;
                we      = 1'b1;
                wa      = 2'd1;
                state_d = DEC;
            end
            DEC: begin
                // compare here sees R0-1, so the loop exits once the counter hits 1
                rea     = 1'b1;
                raa     = 2'd0;
                reb     = 1'b1;
                rab     = 2'd2;
                Sel_alu = SEL_SUB;
                we      = 1'b1;
                wa      = 2'd0;
                state_d = compare ? OUT : MUL;
            end
            OUT: begin
                rea     = 1'b1;
                raa     = 2'd1;
                Sel_alu = SEL_PASS_A;
                OE      = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_factorial_ctrl.sv
// Bench: controller plus register-file/ALU datapath against an arithmetic factorial model.
module tb_factorial_ctrl;

    localparam logic [2:0] SEL_PASS_A = 3'b000;
    localparam logic [2:0] SEL_SUB    = 3'b001;
    localparam logic [2:0] SEL_MUL    = 3'b010;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] n_i;
    logic       compare;
    logic       busy, done, IE, we, rea, reb, OE;
    logic [7:0] data_o;
    logic [1:0] wa, raa, rab;
    logic [2:0] Sel_alu;

    int vectors = 0;
    int fails   = 0;

    always #5 clk = ~clk;

    factorial_ctrl #(
        .SEL_PASS_A(SEL_PASS_A),
        .SEL_SUB   (SEL_SUB),
        .SEL_MUL   (SEL_MUL)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .n_i    (n_i),
        .compare(compare),
        .busy   (busy),
        .done   (done),
        .data_o (data_o),
        .IE     (IE),
        .we     (we),
        .wa     (wa),
        .rea    (rea),
        .raa    (raa),
        .reb    (reb),
        .rab    (rab),
        .OE     (OE),
        .Sel_alu(Sel_alu)
    );

    // datapath: 4x8 register file, ALU, output register
    logic [7:0] rf [4];
    logic [7:0] op_a, op_b, alu_y, out_q;

    assign op_a = rea ? rf[raa] : 8'd0;
    assign op_b = reb ? rf[rab] : 8'd0;

    always_comb begin
        alu_y = 8'd0;
        case (Sel_alu)
            SEL_PASS_A: alu_y = op_a;
            SEL_SUB:    alu_y = op_a - op_b;
            SEL_MUL:    alu_y = 8'(op_a * op_b);
            default:    alu_y = 8'd0;
        endcase
    end

    assign compare = (alu_y == 8'd1);

    always_ff @(posedge clk) begin
        if (we)
            rf[wa] <= IE ? data_o : alu_y;
        if (OE)
            out_q <= alu_y;
    end

    function automatic int fact_mod(input int n);
        int r = 1;
        for (int i = 2; i <= n; i++)
            r = (r * i) % 256;
        return r;
    endfunction

    function automatic logic [23:0] all_outs();
        return {busy, done, IE, we, rea, reb, OE,
                data_o, wa, raa, rab, Sel_alu};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ign_cyc: cycle in which a stray start (n_i=3) is pulsed while busy
    // rst_cyc: cycle in which rst is asserted to abort the run
    task automatic run(input logic [7:0] n, input int ign_cyc,
                       input int rst_cyc);
        int   m, got_cyc;
        logic busy_ok;
        m       = (n == 8'd0) ? 1 : int'(n);
        got_cyc = 0;
        busy_ok = 1'b1;
        @(negedge clk);
        n_i   = n;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n_i   = 8'($urandom);
        for (int c = 1; c <= 600; c++) begin
            if (c == ign_cyc) begin
                start = 1'b1;
                n_i   = 8'd3;
            end
            if (c == rst_cyc) begin
                #2 rst = 1'b1;
                #1 check("async_rst_outs", 32'(all_outs()), 32'd0);
                @(negedge clk);
                check("rst_no_done", 32'(done), 32'd0);
                rst = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    if (done) got_cyc = -1;
                end
                check("abort_no_done", 32'(got_cyc), 32'd0);
                check("abort_idle", 32'(busy), 32'd0);
                return;
            end
            @(negedge clk);
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                got_cyc = c;
                break;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        check("done_cycle", 32'(got_cyc), 32'(2 * m + 4));
        check("out_value", 32'(out_q), 32'(fact_mod(m)));
        check("busy_window", 32'(busy_ok), 32'd1);
        // start raised during DONE must be ignored
        start = 1'b1;
        n_i   = 8'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("post_done_idle", 32'({busy, done}), 32'd0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        n_i   = 8'd0;
        #1;
        check("reset_outs", 32'(all_outs()), 32'd0);
        repeat (2) @(negedge clk);
        check("reset_outs_held", 32'(all_outs()), 32'd0);
        rst = 1'b0;

        run(8'd5, 0, 0);
        run(8'd0, 0, 0);
        run(8'd1, 0, 0);
        run(8'd6, 0, 0);
        run(8'd4, 3, 0);
        run(8'd5, 0, 7);
        run(8'd3, 0, 0);
        run(8'd2, 0, 0);

        for (int i = 0; i < 12; i++)
            run(8'($urandom_range(0, 15)), 0, 0);
        for (int i = 0; i < 2; i++)
            run(8'($urandom_range(16, 255)), 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/factorial_ctrl.md
FACTORIAL_CTRL -- requirements
Module: factorial_ctrl

Interface
REQ-001 Parameters SHALL be: SEL_PASS_A, 3'b000, ALU passes operand A; SEL_SUB, 3'b001, ALU computes A-B; SEL_MUL, 3'b010, ALU computes low 8 bits of A*B.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  one-cycle request to compute n_i!; sampled only in IDLE.
REQ-005 n_i  input  8  operand, sampled on the start edge.
REQ-006 compare  input  1  datapath flag, high when the current ALU result equals 1.
REQ-007 busy  output  1  high in every state except IDLE.
REQ-008 done  output  1  one-cycle pulse; datapath Out holds the result while high.
REQ-009 data_o  output  8  drives datapath Data_i.
REQ-010 IE  output  1  datapath mux select; 1 = data_o, 0 = ALU result.
REQ-011 we / wa  output  1 / 2  register-file write enable / write address.
REQ-012 rea / raa  output  1 / 2  read port A enable / address.
REQ-013 reb / rab  output  1 / 2  read port B enable / address.
REQ-014 OE  output  1  load enable of the datapath output register.
REQ-015 Sel_alu  output  3  ALU operation select.

Function
REQ-016 Register map SHALL be: R0 = n (counter), R1 = acc, R2 = constant 1, R3 unused.
REQ-017 The block SHALL be a Moore FSM; all outputs decode from state (plus the latched operand for data_o).
REQ-018 Unlisted outputs in any state SHALL be 0, i.e. IE, we, rea, reb, OE = 0, wa/raa/rab = 0, Sel_alu = SEL_PASS_A.
REQ-019 IDLE: start=1 latches n_i into an internal 8-bit register, then goes to LOAD_N; otherwise stays in IDLE.
REQ-020 LOAD_N: IE=1, we=1, wa=0, data_o = latched n, or 1 if latched n = 0 (0! = 1! = 1); then LOAD_ACC.
REQ-021 LOAD_ACC: IE=1, we=1, wa=1, data_o=1; then LOAD_ONE.
REQ-022 LOAD_ONE: IE=1, we=1, wa=2, data_o=1; then CHECK.
REQ-023 CHECK: rea=1, raa=0, Sel_alu=SEL_PASS_A; compare=1 goes to OUT, else to MUL.
REQ-024 MUL: rea=1, raa=1, reb=1, rab=0, Sel_alu=SEL_MUL, IE=0, we=1, wa=1 (acc = acc*R0); then DEC.
REQ-025 DEC: rea=1, raa=0, reb=1, rab=2, Sel_alu=SEL_SUB, IE=0, we=1, wa=0 (R0 = R0-1); compare=1 goes to OUT, else to MUL.
REQ-026 OUT: rea=1, raa=1, Sel_alu=SEL_PASS_A, OE=1; then DONE.
REQ-027 DONE: done=1 for exactly one cycle; then IDLE.
REQ-028 With m = max(n,1), done SHALL be high in cycle 2m+4 counted from the start-sampling edge (cycle 1 = LOAD_N).
REQ-029 Arithmetic SHALL wrap modulo 256; no overflow flag is produced.
REQ-030 start while busy=1 SHALL be ignored and SHALL NOT alter the latched operand.
REQ-031 start asserted in the DONE cycle SHALL be ignored; start in the following IDLE cycle SHALL be accepted.
REQ-032 Unreachable state encodings SHALL return to IDLE on the next edge.

Reset
REQ-033 rst=1 SHALL force IDLE and clear the latched operand immediately, regardless of clk.
REQ-034 During reset, busy, done, IE, we, rea, reb and OE SHALL be 0, and data_o, wa, raa, rab and Sel_alu SHALL be 0.
REQ-035 rst asserted mid-computation SHALL abort without asserting done.
REQ-036 The first start after rst deasserts SHALL be accepted normally.

Verification
REQ-037 Bench SHALL pair factorial_ctrl with the factorial datapath block and an ALU using the parameter encodings above.
REQ-038 n_i=5, start pulse -> done high in cycle 14, Out=120, busy high in cycles 1-14.
REQ-039 n_i=0 and n_i=1 -> done in cycle 6, Out=1 in both cases.
REQ-040 n_i=6 -> done in cycle 16, Out=208 (720 mod 256).
REQ-041 n_i=4 started, then start with n_i=3 in cycle 3 -> ignored, done in cycle 12, Out=24.
REQ-042 rst pulsed in cycle 7 of an n_i=5 run -> all outputs 0 asynchronously, no done; a new start with n_i=3 yields Out=6 in cycle 10.
